// File: rtl/cpu_sram_bridge.sv
// Bridges the pipeline's instruction and data SRAM ports onto one valid/ready memory bus.
// Data goes first, then instruction; the pipeline is stalled until both complete.
module cpu_sram_bridge #(
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_sram_en,
    input  logic [DATA_WD/8-1:0] inst_sram_we,
    input  logic [ADDR_WD-1:0]   inst_sram_addr,
    input  logic [DATA_WD-1:0]   inst_sram_wdata,
    output logic [DATA_WD-1:0]   inst_sram_rdata,
    input  logic                 data_sram_en,
    input  logic [DATA_WD/8-1:0] data_sram_we,
    input  logic [ADDR_WD-1:0]   data_sram_addr,
    input  logic [DATA_WD-1:0]   data_sram_wdata,
    output logic [DATA_WD-1:0]   data_sram_rdata,
    output logic                 stallreq_axi,
    output logic                 mem_req,
    output logic [DATA_WD/8-1:0] mem_we,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DATA_WD-1:0]   mem_rdata
);

    localparam int STRB_WD = DATA_WD / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 inst_en_r;
    logic [ADDR_WD-1:0]   inst_addr_r;
    logic                 data_en_r;
    logic [STRB_WD-1:0]   data_we_r;
    logic [ADDR_WD-1:0]   data_addr_r;
    logic [DATA_WD-1:0]   data_wdata_r;
    logic [DATA_WD-1:0]   inst_buf_r;
    logic [DATA_WD-1:0]   data_buf_r;
    logic [DATA_WD-1:0]   inst_rdata_r;
    logic [DATA_WD-1:0]   data_rdata_r;
    logic                 req_any_s;
    logic                 data_write_s;
    logic                 unused_s;

    assign req_any_s       = inst_sram_en | data_sram_en;
    assign data_write_s    = (data_we_r != {STRB_WD{1'b0}});
    assign inst_sram_rdata = inst_rdata_r;
    assign data_sram_rdata = data_rdata_r;
    // Instruction port is read-only; its write-side inputs carry no meaning here.
    assign unused_s        = ^{inst_sram_we, inst_sram_wdata};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and backing-bus drive; bus fields are zero whenever no request is valid.
    always_comb begin
        state_s   = state_r;
        mem_req   = 1'b0;
        mem_we    = {STRB_WD{1'b0}};
        mem_addr  = {ADDR_WD{1'b0}};
        mem_wdata = {DATA_WD{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    state_s = data_sram_en ? D_REQ : I_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            D_REQ: begin
                mem_req   = 1'b1;
                mem_we    = data_we_r;
                mem_addr  = data_addr_r;
                mem_wdata = data_wdata_r;
                if (!mem_ready) begin
                    state_s = D_REQ;
                end else if (data_write_s) begin
                    state_s = inst_en_r ? I_REQ : DONE;
                end else begin
                    state_s = D_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_rvalid) begin
                    state_s = inst_en_r ? I_REQ : DONE;
                end else begin
                    state_s = D_WAIT;
                end
            end
            I_REQ: begin
                mem_req  = 1'b1;
                mem_addr = inst_addr_r;
                if (mem_ready) begin
                    state_s = I_WAIT;
                end else begin
                    state_s = I_REQ;
                end
            end
            I_WAIT: begin
                if (mem_rvalid) begin
                    state_s = DONE;
                end else begin
                    state_s = I_WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pipeline hold: raised combinationally by a fresh request in IDLE, released only in DONE.
    always_comb begin
        stallreq_axi = 1'b0;
        if (rst) begin
            stallreq_axi = 1'b0;
        end else if (state_r == IDLE) begin
            stallreq_axi = req_any_s;
        end else if (state_r == DONE) begin
            stallreq_axi = 1'b0;
        end else begin
            stallreq_axi = 1'b1;
        end
    end

    // Request capture; only IDLE latches, so the stale request seen during DONE is not re-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_en_r    <= 1'b0;
            inst_addr_r  <= {ADDR_WD{1'b0}};
            data_en_r    <= 1'b0;
            data_we_r    <= {STRB_WD{1'b0}};
            data_addr_r  <= {ADDR_WD{1'b0}};
            data_wdata_r <= {DATA_WD{1'b0}};
        end else if ((state_r == IDLE) && req_any_s) begin
            inst_en_r    <= inst_sram_en;
            inst_addr_r  <= inst_sram_addr;
            data_en_r    <= data_sram_en;
            data_we_r    <= data_sram_we;
            data_addr_r  <= data_sram_addr;
            data_wdata_r <= data_sram_wdata;
        end else begin
            inst_en_r    <= inst_en_r;
            inst_addr_r  <= inst_addr_r;
            data_en_r    <= data_en_r;
            data_we_r    <= data_we_r;
            data_addr_r  <= data_addr_r;
            data_wdata_r <= data_wdata_r;
        end
    end

    // Response buffers; rvalid is only honoured in the matching wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_buf_r <= {DATA_WD{1'b0}};
            data_buf_r <= {DATA_WD{1'b0}};
        end else begin
            if ((state_r == D_WAIT) && mem_rvalid) begin
                data_buf_r <= mem_rdata;
            end
            if ((state_r == I_WAIT) && mem_rvalid) begin
                inst_buf_r <= mem_rdata;
            end
        end
    end

    // Output data registers move only at the end of DONE so stalled stages see steady values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_rdata_r <= {DATA_WD{1'b0}};
            data_rdata_r <= {DATA_WD{1'b0}};
        end else if (state_r == DONE) begin
            if (inst_en_r) begin
                inst_rdata_r <= inst_buf_r;
            end
            if (data_en_r && !data_write_s) begin
                data_rdata_r <= data_buf_r;
            end
        end
    end

endmodule

// File: doc/cpu_sram_bridge.md
# cpu_sram_bridge

Responder for the pipeline's two SRAM-style master ports (instruction and data). It serializes both requests onto a single backing memory bus with a valid/ready request channel and a valid-only read-response channel. It holds the pipeline with `stallreq_axi` until the accesses complete, then returns read data with the one-cycle SRAM latency the pipeline expects.

## Interface
Parameters:
- `ADDR_WD`, 64, address width of all ports.
- `DATA_WD`, 64, data width of all ports; byte-strobe width is `DATA_WD/8`.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_sram_en`  in  1  instruction request.
- `inst_sram_we`  in  DATA_WD/8  ignored; instruction accesses are always reads.
- `inst_sram_addr`  in  ADDR_WD  instruction address.
- `inst_sram_wdata`  in  DATA_WD  ignored.
- `inst_sram_rdata`  out  DATA_WD  registered instruction read data.
- `data_sram_en`  in  1  data request.
- `data_sram_we`  in  DATA_WD/8  byte write enables; all zero means read.
- `data_sram_addr`  in  ADDR_WD  data address.
- `data_sram_wdata`  in  DATA_WD  write data.
- `data_sram_rdata`  out  DATA_WD  registered data read data.
- `stallreq_axi`  out  1  pipeline hold request.
- `mem_req`  out  1  backing-bus request valid.
- `mem_we`  out  DATA_WD/8  backing-bus byte enables; zero means read.
- `mem_addr`  out  ADDR_WD  backing-bus address.
- `mem_wdata`  out  DATA_WD  backing-bus write data.
- `mem_ready`  in  1  request accepted when `mem_req & mem_ready`.
- `mem_rvalid`  in  1  read response valid (single beat).
- `mem_rdata`  in  DATA_WD  read response data.

## Operation
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE
  - On `inst_sram_en | data_sram_en`, latch both requests: en, addr, and for data also we and wdata.
  - Next state is D_REQ if data is pending, otherwise I_REQ.
- Ordering: data is serviced before instruction, because the data request belongs to the older instruction.
- D_REQ
  - Drive `mem_req=1` with the latched data request; `mem_*` must stay stable until accepted.
  - On accept:
    - write (we≠0): go to I_REQ if an instruction is pending, else DONE. A write has no response.
    - read: go to D_WAIT.
- D_WAIT: on `mem_rvalid`, capture `mem_rdata` into the data buffer, then go to I_REQ or DONE (same rule as a write in D_REQ).
- I_REQ
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr` = latched instruction address.
  - On accept, go to I_WAIT.
- I_WAIT: on `mem_rvalid`, capture into the instruction buffer and go to DONE.
- DONE
  - `stallreq_axi=0` for exactly one cycle; the pipeline advances at the end of this cycle.
  - Next state is IDLE.
  - The request still presented during DONE is the old one and is not re-latched.
- Output data registers (`*_sram_rdata`)
  - Load from their buffers only on the clock edge that ends DONE, and only for ports that had a read in that transaction.
  - Otherwise they hold their value, so stalled stages see constant data.
- `mem_rvalid` outside D_WAIT/I_WAIT is ignored.
- When `mem_req=0`, drive `mem_we`, `mem_addr` and `mem_wdata` to 0.
- `stallreq_axi = !rst & ((IDLE & (inst_sram_en | data_sram_en)) | state ∉ {IDLE, DONE})`.

## Timing
- Reset: state IDLE; `mem_req=0`; `mem_we/addr/wdata=0`; both rdata outputs 0; buffers and latched requests 0; `stallreq_axi=0` while `rst` is high.
- Reset mid-transaction: abandons the transaction immediately. Any later `mem_rvalid` is ignored; the backing memory is reset together with the bridge.
- `stallreq_axi` rises combinationally in the same cycle a request appears in IDLE.
- `mem_rvalid` arrives no earlier than the cycle after acceptance.
- Best-case instruction-only read (ready at once, rvalid one cycle later):
  - C0: IDLE, stall=1.
  - C1: I_REQ, accepted.
  - C2: I_WAIT, rvalid.
  - C3: DONE, stall=0.
  - C4: `inst_sram_rdata` valid; a new request may be presented in C4 and is handled starting from IDLE.
- Combined data-read plus instruction: best case 6 cycles from request to rdata valid.
- Data write plus instruction: best case 5 cycles.
- Each cycle of `mem_ready=0` or `mem_rvalid` delay extends the current state by one cycle.
- Back-to-back: after DONE, at least one IDLE cycle follows; a request present in that cycle sets stall that same cycle.

## Test plan
- Instruction fetch only: addr 0x80000000, ready=1, rvalid next cycle with 0x00000013 -> stall high C0–C2, low C3; `inst_sram_rdata=0x13` from C4; `data_sram_rdata` unchanged.
- Data read plus fetch together: data addr 0x1000 returns 0xDEADBEEF, inst returns 0x13 -> bus order data then inst; both outputs update on the same edge at the end of DONE.
- Data write `we=0xFF`, wdata 0x55AA, plus fetch -> one write request with no wait state, then instruction read; `data_sram_rdata` holds its previous value.
- Backpressure: `mem_ready` low 3 cycles, `mem_rvalid` delayed 4 cycles -> `mem_*` stable while unaccepted; stall extended by exactly 7 cycles; rdata outputs constant until the end of DONE.
- Async reset asserted in D_WAIT, stray `mem_rvalid` after release -> immediate IDLE, all outputs 0, stray response ignored.
- Back-to-back fetches at 0x0, 0x4, 0x8 -> each produces exactly one bus read; no duplicate request during DONE.
